// File: rtl/rv32_pkg.sv
// Shared rv32 decode definitions: opcodes, bubble encoding, immediate
// classification and generation, plus the pipeline register payloads.
package rv32_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;

  // addi x0,x0,0
  localparam logic [31:0] NOP_INSTR = 32'h00000013;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_type_e;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic        valid;
  } ifde_t;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [31:0] imm;
    logic        valid;
  } deexe_t;

  function automatic imm_type_e imm_type(input logic [6:0] op);
    imm_type_e t;
    t = IMM_NONE;
    case (op)
      OP_IMM, OP_LOAD, OP_JALR: t = IMM_I;
      OP_STORE:                 t = IMM_S;
      OP_BRANCH:                t = IMM_B;
      OP_LUI, OP_AUIPC:         t = IMM_U;
      OP_JAL:                   t = IMM_J;
      default:                  t = IMM_NONE;
    endcase
    return t;
  endfunction

  function automatic logic [31:0] imm_gen(input logic [31:0] ins);
    logic [31:0] imm;
    imm = '0;
    case (imm_type(ins[6:0]))
      IMM_I: imm = {{20{ins[31]}}, ins[31:20]};
      IMM_S: imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      IMM_B: imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      IMM_U: imm = {ins[31:12], 12'b0};
      IMM_J: imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/regfile.sv
// 32x32 register file, two combinational reads and one synchronous write.
// x0 reads as zero; no write-to-read bypass here (the decode stage owns it).
module regfile (
  input  logic        clk,
  input  logic        we_i,
  input  logic [4:0]  waddr_i,
  input  logic [31:0] wdata_i,
  input  logic [4:0]  raddr_a_i,
  input  logic [4:0]  raddr_b_i,
  output logic [31:0] rdata_a_o,
  output logic [31:0] rdata_b_o
);

  logic [31:0] mem_q [32];

  // Contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (we_i && (waddr_i != 5'd0)) mem_q[waddr_i] <= wdata_i;
  end

  assign rdata_a_o = (raddr_a_i == 5'd0) ? 32'd0 : mem_q[raddr_a_i];
  assign rdata_b_o = (raddr_b_i == 5'd0) ? 32'd0 : mem_q[raddr_b_i];

endmodule

// File: rtl/decode_stage.sv
// rv32 decode stage: IF/DE register, operand resolution with forwarding and
// write-back bypass, immediate generation, and the DE/EXE register.
module decode_stage
  import rv32_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = rv32_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] instr_if,
  input  logic [31:0] pc_if,
  input  logic        valid_if,
  input  logic        flush,
  input  logic        stall,
  input  logic        hazard_a,
  input  logic        hazard_b,
  input  logic [31:0] data_a_mgr,
  input  logic [31:0] data_b_mgr,
  input  logic        wb_en,
  input  logic [4:0]  wb_rd,
  input  logic [31:0] wb_data,
  output logic [31:0] instr_de,
  output logic        stall_if,
  output logic [31:0] instr_exe,
  output logic [31:0] pc_exe,
  output logic [31:0] rs1_data_exe,
  output logic [31:0] rs2_data_exe,
  output logic [31:0] imm_exe,
  output logic        valid_exe
);

  localparam ifde_t  DE_EMPTY  = '{instr: NOP_INSTR, pc: 32'd0, valid: 1'b0};
  localparam deexe_t EXE_EMPTY = '{instr: NOP_INSTR, pc: 32'd0, rs1: 32'd0,
                                   rs2: 32'd0, imm: 32'd0, valid: 1'b0};

  ifde_t  de_q, de_d;
  deexe_t exe_q, exe_d;

  logic [4:0]  rs1_idx, rs2_idx;
  logic [31:0] rf_a, rf_b;
  logic [31:0] rs1_val, rs2_val;

  assign rs1_idx = de_q.instr[19:15];
  assign rs2_idx = de_q.instr[24:20];

  regfile u_regfile (
    .clk       (clk),
    .we_i      (wb_en),
    .waddr_i   (wb_rd),
    .wdata_i   (wb_data),
    .raddr_a_i (rs1_idx),
    .raddr_b_i (rs2_idx),
    .rdata_a_o (rf_a),
    .rdata_b_o (rf_b)
  );

  // x0 wins over forwarding because the hazard manager does not filter it.
  function automatic logic [31:0] resolve(input logic [4:0]  rs,
                                          input logic        haz,
                                          input logic [31:0] fwd,
                                          input logic [31:0] rf);
    logic [31:0] v;
    v = rf;
    if (rs == 5'd0)                        v = 32'd0;
    else if (haz)                          v = fwd;
    else if (wb_en && (wb_rd == rs))       v = wb_data;
    return v;
  endfunction

  assign rs1_val = resolve(rs1_idx, hazard_a, data_a_mgr, rf_a);
  assign rs2_val = resolve(rs2_idx, hazard_b, data_b_mgr, rf_b);

  always_comb begin
    de_d = de_q;
    if (flush)       de_d = DE_EMPTY;
    else if (!stall) de_d = '{instr: valid_if ? instr_if : NOP_INSTR,
                              pc: pc_if, valid: valid_if};
  end

  always_comb begin
    exe_d = EXE_EMPTY;
    if (!flush && !stall)
      exe_d = '{instr: de_q.instr, pc: de_q.pc, rs1: rs1_val, rs2: rs2_val,
                imm: imm_gen(de_q.instr), valid: de_q.valid};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      de_q  <= DE_EMPTY;
      exe_q <= EXE_EMPTY;
    end else begin
      de_q  <= de_d;
      exe_q <= exe_d;
    end
  end

  assign stall_if     = stall & ~flush;
  assign instr_de     = de_q.instr;
  assign instr_exe    = exe_q.instr;
  assign pc_exe       = exe_q.pc;
  assign rs1_data_exe = exe_q.rs1;
  assign rs2_data_exe = exe_q.rs2;
  assign imm_exe      = exe_q.imm;
  assign valid_exe    = exe_q.valid;

endmodule

// File: doc/decode_stage.md
# decode_stage

Decode stage of the rv32 pipeline, between fetch and execute. Holds the IF/DE pipeline register and presents `instr_de` to the hazard/forwarding manager. Reads the register file, selects forwarded operands using the manager's `hazard_a`/`hazard_b`/`data_*_mgr`, generates the immediate, and loads the DE/EXE register. On `stall` it holds IF/DE and inserts a bubble into EXE; on `flush` it squashes both registers.

## Interface
Parameters:
- `NOP_INSTR`, default 32'h00000013: bubble/squash encoding (`addi x0,x0,0`).

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: synchronous, active-high reset, sampled on `clk` rising edge.
- `instr_if` in 32: fetched instruction.
- `pc_if` in 32: PC of `instr_if`.
- `valid_if` in 1: `instr_if` is valid.
- `flush` in 1: redirect from execute; squash DE and EXE.
- `stall` in 1: from hazard manager; load-use stall.
- `hazard_a`, `hazard_b` in 1 each: forward `data_a_mgr`/`data_b_mgr` for rs1/rs2.
- `data_a_mgr`, `data_b_mgr` in 32 each: forwarded operand values.
- `wb_en` in 1: register-file write enable.
- `wb_rd` in 5: write-back destination register.
- `wb_data` in 32: write-back data.
- `instr_de` out 32: IF/DE instruction, to hazard manager.
- `stall_if` out 1: hold fetch PC; equals `stall & ~flush`.
- `instr_exe`, `pc_exe` out 32 each: DE/EXE instruction and PC.
- `rs1_data_exe`, `rs2_data_exe` out 32 each: resolved operands.
- `imm_exe` out 32: sign-extended immediate.
- `valid_exe` out 1: EXE slot holds a real instruction.

## Operation
- IF/DE register (`instr_de`, `pc_de`, `valid_de`): updates every edge with this priority:
  - `rst`: `NOP_INSTR`, 0, 0.
  - `flush`: `NOP_INSTR`, 0, 0.
  - `stall`: holds.
  - Otherwise: loads `instr_if`, `pc_if`, `valid_if`. When `valid_if`=0 it loads `NOP_INSTR`.
- Operand resolution for rs1 (rs2 is the same, using `[24:20]`, `hazard_b`, `data_b_mgr`), in priority order:
  1. rs field == 0 → 0. This applies even if the hazard input is asserted; the manager does not filter x0.
  2. `hazard_a` → `data_a_mgr`.
  3. `wb_en && wb_rd==rs1 && wb_rd!=0` → `wb_data` (write-first bypass).
  4. Otherwise the register file read.
- Register file: 32x32, two combinational reads, one synchronous write on `wb_en`. Writes to x0 are ignored. Contents are not cleared by `rst`.
- Immediate, selected by `instr_de[6:0]`:
  - I-type (0010011, 0000011, 1100111): sext `[31:20]`.
  - S-type (0100011): sext `{[31:25],[11:7]}`.
  - B-type (1100011): sext `{[31],[7],[30:25],[11:8],0}`.
  - U-type (0110111, 0010111): `{[31:12],12'b0}`.
  - J-type (1101111): sext `{[31],[19:12],[20],[30:21],0}`.
  - Any other opcode: 0.
- DE/EXE register, priority order:
  - `rst`, `flush`, or `stall`: loads a bubble — `instr_exe`=`NOP_INSTR`, `valid_exe`=0, `pc_exe`/`imm_exe`/`rs*_data_exe`=0.
  - Otherwise: loads `instr_de`, `pc_de`, the resolved operands, the immediate, and `valid_de`.

## Timing
- Reset values: `instr_de`=`instr_exe`=`NOP_INSTR`; `pc_exe`, `rs1_data_exe`, `rs2_data_exe`, `imm_exe`, `valid_exe` = 0; `stall_if`=0 unless `stall` is asserted.
- Latency: instruction accepted at edge N appears on `instr_de` after N and on `instr_exe` after N+1.
- `stall` held k cycles: `instr_de` frozen for k cycles, k bubbles enter EXE, then the instruction proceeds.
- `flush` and `stall` in the same cycle: flush wins, `stall_if`=0.
- Forwarding inputs and `wb_*` are sampled combinationally in the cycle the instruction sits in DE and captured at the DE→EXE edge.
- `rst` mid-stall: next state is the reset state; the stall is released.

## Structure
- Shared package `rv32_pkg` holds:
  - Opcode constants: `OP_LUI`, `OP_AUIPC`, `OP_JAL`, `OP_JALR`, `OP_BRANCH`, `OP_LOAD`, `OP_STORE`, `OP_IMM`, `OP_REG`.
  - `NOP_INSTR` value.
  - Immediate-type enum.
- One sub-module, `regfile`: 2R1W, x0 hardwired to zero, no bypass. Bypass lives in `decode_stage`.

## Test plan
- Reset → `instr_de`=`instr_exe`=32'h00000013, `valid_exe`=0, all data outputs 0.
- Write x5=32'hDEADBEEF, then `addi x6,x5,1` → `rs1_data_exe`=32'hDEADBEEF, `imm_exe`=1. Repeat with the write and read in the same cycle → bypass gives the same value.
- `hazard_a`=1, `data_a_mgr`=32'h12345678, rs1=x3 → `rs1_data_exe`=32'h12345678. Same stimulus with rs1=x0 → 0.
- `stall` held 2 cycles with `beq` in DE → `instr_de` unchanged for 2 cycles, two NOP bubbles (`valid_exe`=0) in EXE, then `beq` reaches EXE with `imm_exe` correct for offset -8 (32'hFFFFFFF8).
- `flush` and `stall` asserted together → both registers NOP, `stall_if`=0. Next `instr_if` is loaded on the following edge.
- `jal` with offset +2048 → `imm_exe`=32'h00000800. `lui x1,0xABCDE` → `imm_exe`=32'hABCDE000.
